rx_receiver: RTL
================

# rx_receiver

Serial receive end of the CRC network link. It samples the single-wire line driven by the board's `tx_transmitter` and rebuilds the 136-bit packet. It checks the packet's CRC-8 on the fly and reports the outcome to the Rx board's top level through the LED and HEX status logic. It sits between a GPIO input pin and the Rx display/decode logic.

## Interface
Parameters:
- `BIT_CYCLES`, default 5208: clock cycles per line bit (9600 bit/s at 50 MHz). Legal range is ≥ 4.
- `PKT_W`, default 136: packet width in bits.

Ports:
- `clk`  input  1  system clock, 50 MHz (`CLOCK_50` at top).
- `rst_n`  input  1  asynchronous, active-low reset.
- `rx_line`  input  1  serial line, asynchronous to `clk`; idles high.
- `rx_packet`  output  PKT_W  last received packet, MSB = first bit on the line.
- `rx_valid`  output  1  one-cycle pulse at the end of every frame.
- `crc_ok`  output  1  CRC result of the last frame; held until the next `rx_valid`.
- `frame_err`  output  1  stop-bit error on the last frame; held until the next `rx_valid`.
- `rx_busy`  output  1  high while a frame is in progress (any state other than IDLE).

## Operation
- **Frame format:** 1 start bit (0), then PKT_W data bits MSB first, then 1 stop bit (1). Each bit lasts `BIT_CYCLES` clocks.
- **Packet layout:**
  - `[135:8]` is the payload.
  - `[7:0]` is the CRC-8: polynomial 0x07 (x⁸+x²+x+1), init 0x00, no reflection, no final XOR, computed over `[135:8]` MSB first.
- **Input synchronisation:** `rx_line` passes through a 2-FF synchroniser before any use.
- **State machine (states IDLE, START, DATA, STOP, WAIT_IDLE):**
  - IDLE: when a falling edge is detected on the synchronised line, load the bit timer with `BIT_CYCLES/2 - 1` and go to START.
  - START: at timer expiry, if the line is still 0, clear the CRC register and bit counter and go to DATA. If the line is 1, it was a glitch: return to IDLE with no `rx_valid`.
  - DATA: sample at mid-bit every `BIT_CYCLES` cycles and shift the bit into the shift register.
    - While bit index < 128, also feed the bit into the CRC.
    - After bit index PKT_W-1, go to STOP.
  - STOP: sample at mid-bit.
    - If 1: `frame_err`=0 and go to IDLE.
    - If 0: `frame_err`=1 and go to WAIT_IDLE.
    - In both cases `rx_packet` ← shift register, `crc_ok` ← (CRC register == received `[7:0]`), and `rx_valid` pulses.
  - WAIT_IDLE: stay until the synchronised line is 1, then go to IDLE. This prevents a held-low line from retriggering a frame.
- `rx_packet`, `crc_ok` and `frame_err` update only at the STOP sample and hold otherwise.
- **Reset**, asserted at any time including mid-frame:
  - State returns to IDLE; the timer, counter, CRC and shift register clear.
  - Outputs: `rx_packet`=0, `rx_valid`=0, `crc_ok`=0, `frame_err`=0, `rx_busy`=0.
  - The synchroniser flops reset to 1 (idle), so a reset release never produces a false start.

## Timing
- The falling edge is detected 2 cycles after it arrives on `rx_line`, because of synchroniser latency.
- Data bit k is sampled `BIT_CYCLES/2 + (k+1)·BIT_CYCLES` cycles after the detected start edge.
- `rx_valid` is registered: it goes high in the cycle after the stop-bit sample and lasts exactly 1 cycle. `rx_packet`, `crc_ok` and `frame_err` are valid in that same cycle.
- `rx_busy` rises the cycle after start-edge detection. It falls together with the `rx_valid` pulse, or on exit from WAIT_IDLE.
- A new start edge is accepted from the first IDLE cycle onward, so back-to-back frames need no extra idle time beyond the stop bit.
- **Timer:** counts down and reloads with `BIT_CYCLES-1`. Its width is `$clog2(BIT_CYCLES)`.
- **Bit counter:** 8 bits, no wrap-around beyond PKT_W.

## Structure
- **Shared package `crc_net_pkg`** holds:
  - `PKT_W`=136, `CRC_W`=8, `CRC_POLY`=8'h07, `PAYLOAD_W`=128.
  - The Rx state enum.
  - The Tx side uses this same package so that both ends compute identical CRCs.
- **Sub-module `crc8_serial`:** ports `clk`, `rst_n`, `clr`, `en`, `din`, `crc[7:0]`. It is a one-bit-per-enable LFSR; the feedback bit is `crc[7] ^ din`.

## Test plan
- **Good frame:** reset, then send a packet with payload all 0 and CRC 0x00 at `BIT_CYCLES`=8. Required: exactly one `rx_valid`, `rx_packet`=0, `crc_ok`=1, `frame_err`=0.
- **CRC mismatch:** send payload 0x01 in bits `[15:8]` with the correct CRC 0x07, then the same payload with CRC 0x06. Required: `crc_ok`=1, then `crc_ok`=0, with `rx_packet` equal to the sent value both times.
- **Start-bit glitch:** drive the line low for 2 cycles, then high. Required: no `rx_valid`, and `rx_busy` returns to 0 after `BIT_CYCLES/2`+3 cycles.
- **Stop-bit error:** hold the line low through the stop bit for 3 bit times, then release. Required: `rx_valid` with `frame_err`=1, `rx_busy`=1 until the line goes high, and no second frame.
- **Reset mid-frame:** assert `rst_n`=0 at data bit 50, release, then send a good frame. Required: all outputs 0 during reset, and the next frame is received correctly.
- **Back-to-back frames:** send two frames with only the stop bit between them, payloads 0xA5…A5 and 0x5A…5A with correct CRCs. Required: two `rx_valid` pulses, both with `crc_ok`=1.

Source files
------------

// File: rtl/crc_net_pkg.sv
// Shared definitions for the CRC network link (Tx and Rx ends).
// Holds the packet geometry, the CRC-8 polynomial and the Rx state encoding.
package crc_net_pkg;

    localparam int unsigned PKT_W     = 136;
    localparam int unsigned CRC_W     = 8;
    localparam int unsigned PAYLOAD_W = PKT_W - CRC_W;

    localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_e;

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (poly 0x07, init 0, MSB first), one bit per enable.
// Ports:
//   clk, rst_n : clock, async active-low reset (clears the CRC)
//   clr        : synchronous clear to 0 (has priority over en)
//   en         : shift din into the CRC this cycle
//   din        : serial data bit
//   crc        : current CRC register value
module crc8_serial
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);
    import crc_net_pkg::*;

    logic [CRC_W-1:0] r_crc;
    logic             w_fb;
    logic [CRC_W-1:0] w_crc_nxt;

    // Galois-form LFSR step: shift left, fold in the polynomial on feedback.
    always_comb begin
        w_fb      = r_crc[CRC_W-1] ^ din;
        w_crc_nxt = {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? CRC_POLY : CRC_W'(0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= '0;
        end else if (clr) begin
            r_crc <= '0;
        end else if (en) begin
            r_crc <= w_crc_nxt;
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/rx_receiver.sv
// Serial receive end of the CRC network link.
// Samples the idle-high line at mid-bit, rebuilds the packet (MSB first),
// checks the CRC-8 on the fly and reports the result once per frame.
// Ports:
//   clk, rst_n  : system clock, async active-low reset
//   rx_line     : asynchronous serial input, idles high
//   rx_packet   : last received packet (MSB = first bit on the line)
//   rx_valid    : one-cycle pulse at the end of every frame
//   crc_ok      : CRC result of the last frame, held until next rx_valid
//   frame_err   : stop-bit error of the last frame, held until next rx_valid
//   rx_busy     : high while a frame is in progress
module rx_receiver
#(
    parameter int unsigned BIT_CYCLES = 5208,
    parameter int unsigned PKT_W      = 136
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_line,
    output logic [PKT_W-1:0] rx_packet,
    output logic             rx_valid,
    output logic             crc_ok,
    output logic             frame_err,
    output logic             rx_busy
);
    import crc_net_pkg::*;

    localparam int unsigned TMR_W = $clog2(BIT_CYCLES);
    localparam int unsigned CNT_W = 8;

    localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(BIT_CYCLES / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_LOAD = TMR_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(PKT_W - 1);
    localparam logic [CNT_W-1:0] CRC_BITS  = CNT_W'(PKT_W - CRC_W);

    // Synchroniser and edge-detect history, all idle-high so reset release is quiet.
    logic r_sync1;
    logic r_sync2;
    logic r_sync_d;
    logic w_line;
    logic w_fall;

    rx_state_e        r_state;
    rx_state_e        w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    logic [PKT_W-1:0] r_shift;
    logic [PKT_W-1:0] w_shift_nxt;
    logic             w_tick;
    logic             w_crc_clr;
    logic             w_crc_en;
    logic [CRC_W-1:0] w_crc;
    logic             w_capture;
    logic             w_valid_nxt;
    logic             w_busy_nxt;

    logic [PKT_W-1:0] r_packet;
    logic             r_valid;
    logic             r_crc_ok;
    logic             r_frame_err;
    logic             r_busy;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_sync1  <= rx_line;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    assign w_line = r_sync2;
    assign w_fall = r_sync_d & ~r_sync2;
    assign w_tick = (r_timer == '0);

    // CRC runs over the payload bits only; the trailing CRC byte is just stored.
    crc8_serial u_crc
    (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_crc_clr),
        .en    (w_crc_en),
        .din   (w_line),
        .crc   (w_crc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, bit timer, bit counter and shift-register control.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_crc_clr     = 1'b0;
        w_crc_en      = 1'b0;
        w_capture     = 1'b0;
        w_valid_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_timer_nxt = HALF_LOAD;
                    w_state_nxt = START;
                end
            end

            START: begin
                if (w_tick) begin
                    w_timer_nxt = FULL_LOAD;
                    if (!w_line) begin
                        w_crc_clr     = 1'b1;
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = DATA;
                    end else begin
                        w_state_nxt   = IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end

            DATA: begin
                if (w_tick) begin
                    w_timer_nxt = FULL_LOAD;
                    w_shift_nxt = {r_shift[PKT_W-2:0], w_line};
                    w_crc_en    = (r_bit_cnt < CRC_BITS);
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end

            STOP: begin
                if (w_tick) begin
                    w_capture   = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = w_line ? IDLE : WAIT_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end

            WAIT_IDLE: begin
                if (w_line) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_timer   <= w_timer_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // Registered status outputs; packet and flags hold between stop samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_packet    <= '0;
            r_valid     <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            if (w_capture) begin
                r_packet    <= r_shift;
                r_crc_ok    <= (w_crc == r_shift[CRC_W-1:0]);
                r_frame_err <= ~w_line;
            end
        end
    end

    assign rx_packet = r_packet;
    assign rx_valid  = r_valid;
    assign crc_ok    = r_crc_ok;
    assign frame_err = r_frame_err;
    assign rx_busy   = r_busy;

endmodule
